// File: rtl/add_arbiter.sv
// add_arbiter: time-shares one registered adder (y <= a + b, 1-cycle latency) among N requesters.
// Define ADD_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; default build is round-robin.
module add_arbiter #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  input  logic [W-1:0]   add_y,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_y,
  output logic [IW-1:0]  rsp_id,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_reg;
  logic [W-1:0]  op_a_reg;
  logic [W-1:0]  op_b_reg;
  logic [IW-1:0] op_id_reg;
  logic [W-1:0]  rsp_y_reg;
  logic          rsp_valid_reg;

  logic [W-1:0]  a_arr [N];
  logic [W-1:0]  b_arr [N];
  logic [IW-1:0] grant_idx;
  logic          grant_any;
  logic          accept;

  assign grant_any = |req_valid;
  assign accept    = (state_reg == IDLE) && grant_any && !rst;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_req
      assign a_arr[gi]     = req_a[gi*W +: W];
      assign b_arr[gi]     = req_b[gi*W +: W];
      assign req_ready[gi] = accept && (grant_idx == IW'(gi));
    end
  endgenerate

`ifdef ADD_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_valid[i]) grant_idx = IW'(i);
    end
  end
`else
  logic [IW-1:0] last_grant_reg;
  logic [IW-1:0] cand;

  // Scan from farthest to nearest so the requester right after last_grant is assigned last and wins.
  always_comb begin
    grant_idx = '0;
    cand      = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last_grant_reg) + k) % N);
      if (req_valid[cand]) grant_idx = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= IW'(N - 1);
    end else if (accept) begin
      last_grant_reg <= grant_idx;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      op_id_reg     <= '0;
      rsp_y_reg     <= '0;
      rsp_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_a_reg  <= a_arr[grant_idx];
            op_b_reg  <= b_arr[grant_idx];
            op_id_reg <= grant_idx;
            state_reg <= ISSUE;
          end
        end
        ISSUE: state_reg <= WAIT;
        // Adder captured the operands at the end of ISSUE; its result is valid now.
        WAIT: begin
          rsp_y_reg     <= add_y;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign add_a     = op_a_reg;
  assign add_b     = op_b_reg;
  assign rsp_y     = rsp_y_reg;
  assign rsp_id    = op_id_reg;
  assign rsp_valid = rsp_valid_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: directed cases plus randomized ops against a grant/sum model.
// Build with ADD_ARB_FIXED_PRIO_EN defined to check the fixed-priority variant.
module tb_add_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_y;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_y;
  logic [IW-1:0]  rsp_id;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int last_g = N - 1;

  add_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_y(add_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // The shared adder the arbiter drives.
  always_ff @(posedge clk) add_y <= add_a + add_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Which requester should win given the asserted set.
  function automatic int pick(input logic [N-1:0] mask);
`ifdef ADD_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (mask[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (mask[(last_g + k) % N]) return (last_g + k) % N;
`endif
    return 0;
  endfunction

  // Starts and ends just after a negedge with the DUT idle.
  task automatic do_op(input logic [N-1:0] mask, input int bp,
                       input logic [N*W-1:0] av, input logic [N*W-1:0] bv);
    int g;
    logic [W-1:0] ea, eb, ey;
    g  = pick(mask);
    ea = av[g*W +: W];
    eb = bv[g*W +: W];
    ey = W'((int'(ea) + int'(eb)) % (1 << W));
    rsp_ready = 1'b0;
    req_a = av;
    req_b = bv;
    req_valid = mask;
    #1;
    check("idle_req_ready", 32'(req_ready), 32'(1 << g));
    check("idle_busy", 32'(busy), 0);
    @(negedge clk);
    check("issue_req_ready", 32'(req_ready), 0);
    check("issue_rsp_valid", 32'(rsp_valid), 0);
    check("issue_busy", 32'(busy), 1);
    check("issue_add_a", 32'(add_a), 32'(ea));
    check("issue_add_b", 32'(add_b), 32'(eb));
    @(negedge clk);
    check("wait_rsp_valid", 32'(rsp_valid), 0);
    check("wait_add_a", 32'(add_a), 32'(ea));
    @(negedge clk);
    check("resp_rsp_valid", 32'(rsp_valid), 1);
    check("resp_rsp_y", 32'(rsp_y), 32'(ey));
    check("resp_rsp_id", 32'(rsp_id), 32'(g));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 1);
      check("bp_rsp_y", 32'(rsp_y), 32'(ey));
      check("bp_rsp_id", 32'(rsp_id), 32'(g));
      check("bp_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("done_busy", 32'(busy), 0);
    check("done_rsp_valid", 32'(rsp_valid), 0);
    req_valid = '0;
    last_g = g;
    $display("op mask=%b id=%0d a=%h b=%h y=%h bp=%0d", mask, g, ea, eb, ey, bp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_y", 32'(rsp_y), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_add_a", 32'(add_a), 0);
    check("rst_add_b", 32'(add_b), 0);
    rst = 1'b0;
    req_valid = '0;
    last_g = N - 1;
    @(negedge clk);
    check("idle_novalid_busy", 32'(busy), 0);
    check("idle_novalid_ready", 32'(req_ready), 0);
    $display("reset done");
  endtask

  initial begin
    rst_ready_init();
    do_reset();

    do_op(4'b0100, 0, 32'h0001_0000, 32'h0002_0000);
    do_op(4'b0001, 0, 32'h0000_00FF, 32'h0000_0001);
    do_op(4'b0001, 0, 32'h0000_00AA, 32'h0000_0055);

    do_reset();
    for (int i = 0; i < 8; i++) do_op(4'b1111, 0, $urandom, $urandom);

    do_op(4'b1000, 5, $urandom, $urandom);

    // Abort an op during WAIT; no response may appear and arbitration restarts at index 0.
    req_a = $urandom;
    req_b = $urandom;
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("abort_wait_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_g = N - 1;
    check("abort_rsp_valid", 32'(rsp_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_rsp_y", 32'(rsp_y), 0);
    @(negedge clk);
    check("abort_no_resp", 32'(rsp_valid), 0);
    $display("mid-op reset done");
    do_op(4'b1111, 0, $urandom, $urandom);

    for (int i = 0; i < 40; i++)
      do_op(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), $urandom, $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic rst_ready_init();
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

endmodule
